bg_pic_writer: RTL
==================

// Module: bg_pic_writer
// PURPOSE
//   Writer side of the background-picture path. Takes the HPS ioctl byte stream
//   for the background image, packs byte pairs into 16-bit words and queues them.
//   It then drains them into SDRAM over a req/ack write handshake.
//   The pixel fetcher reads these words back, one word per visible pixel.
//   Sits between hps_io (ioctl domain) and the sdram write port.
// PARAMETERS
//   FIFO_DEPTH   8        word FIFO entries; power of two, >= 2
//   ADDR_W       25       byte address width of dn_addr / mem_addr
//   FRAME_BYTES  614400   bytes required for a complete 640x480x16bpp picture
// PORTS
//   clk_25        in   1        system clock (ioctl domain)
//   RESET_L       in   1        asynchronous active-low reset
//   dn_en         in   1        download active AND ioctl_index==2
//   dn_wr         in   1        byte strobe, one cycle, qualified by dn_en
//   dn_addr       in   ADDR_W   byte address of dn_data
//   dn_data       in   8        download byte
//   mem_req       out  1        write request, level, held until mem_ack
//   mem_addr      out  ADDR_W   word-aligned byte address (bit0 = 0)
//   mem_din       out  16       write data
//   mem_ack       in   1        one-cycle accept pulse from the SDRAM side
//   busy          out  1        high in LOAD or DRAIN
//   pic_valid     out  1        complete, error-free picture is in SDRAM
//   err_overflow  out  1        sticky: word dropped because FIFO was full
//   err_addr      out  1        sticky: odd byte arrived without its even partner
//   checksum      out  16       see CONFIGURATION
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, FIFO empty, pair register empty, count 0.
//   FSM: IDLE -(dn_en rise)-> LOAD -(dn_en fall)-> DRAIN -(FIFO empty & !mem_req)-> DONE.
//   DONE -(dn_en rise)-> LOAD.
//   A dn_en rise in any state clears pic_valid, the errors, the byte count,
//   checksum and pair register. The FIFO is not flushed; queued words still drain.
//   Packing: a byte at an even addr goes to din[7:0] and is latched with addr.
//   A byte at addr+1 goes to din[15:8] and completes the word, which is pushed
//   the same cycle. No push happens for a lone even byte.
//   An odd byte with no pending even byte at addr-1: byte dropped, err_addr=1.
//   An even byte while a half word is pending: the old half is pushed with
//   din[15:8]=0, then the new byte is latched.
//   dn_en fall with a half word pending: that half is pushed with din[15:8]=0.
//   Count: +1 per accepted byte. It saturates at 2^ADDR_W-1 and is never dropped for overflow.
//   Full: a push while FIFO is full drops the new word; err_overflow=1; the
//   FIFO contents are unchanged. A pop and a push in the same cycle on a
//   full FIFO is accepted, with no error.
//   Handshake: mem_req rises the cycle after the FIFO becomes non-empty.
//   mem_addr and mem_din stay stable while mem_req=1.
//   On mem_ack: pop the FIFO. mem_req drops for at least one cycle before the next request.
//   Minimum spacing is 2 cycles per word. mem_ack while mem_req=0 is ignored.
//   DRAIN->DONE: pic_valid = (count >= FRAME_BYTES) & !err_overflow & !err_addr.
//   busy = (state==LOAD)|(state==DRAIN).
//   dn_wr while dn_en=0 is ignored.
//   Reset mid-transfer: mem_req drops asynchronously and queued words are lost.
//   The SDRAM side must tolerate an abandoned request.
// CONFIGURATION
//   BGW_CHECKSUM_EN defined: checksum = 16-bit wrap-around sum of accepted bytes,
//   including bytes later dropped on overflow. It is cleared at dn_en rise and
//   frozen outside LOAD.
//   Not defined: checksum tied to 16'h0000 and no adder is built.
// TESTING
//   Write bytes 0x11@0, 0x22@1 with mem_ack 1 cycle after req -> one write, addr 0, din 16'h2211.
//   Then pic_valid=0, because the count is below FRAME_BYTES.
//   Stream FRAME_BYTES bytes, mem_ack every 4th cycle -> 307200 writes at
//   sequential even addrs, pic_valid=1 in DONE, both errors 0.
//   Hold mem_ack low; push FIFO_DEPTH+1 words -> 9th word dropped, err_overflow=1.
//   Then release ack -> exactly 8 writes and pic_valid=0.
//   Odd byte 0x5A@3 first -> no write, err_addr=1. Lone 0x7E@4 then dn_en fall
//   -> write addr 4, din 16'h007E.
//   Assert RESET_L=0 while mem_req=1 -> mem_req=0 the same cycle, all outputs 0.
//   A new download afterwards completes normally.
//   BGW_CHECKSUM_EN: bytes 0xFF,0xFF,0x03 -> checksum 16'h0201; without the macro -> 16'h0000.

Source files
------------

// File: rtl/bg_pic_writer.sv
// rtl/bg_pic_writer.sv - background picture writer: ioctl bytes -> 16-bit word FIFO -> SDRAM req/ack writes
// Optional feature macro: BGW_CHECKSUM_EN (16-bit byte checksum; when undefined the output is tied to zero)
module bg_pic_writer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_W      = 25,
    parameter int FRAME_BYTES = 614400
) (
    input  logic              clk_25,
    input  logic              RESET_L,
    input  logic              dn_en,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [7:0]        dn_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic              busy,
    output logic              pic_valid,
    output logic              err_overflow,
    output logic              err_addr,
    output logic [15:0]       checksum
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WA = ADDR_W - 1;      // word address width
    localparam int EW = WA + 16;         // FIFO entry: {word address, data}
    localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(FRAME_BYTES);
    localparam logic [PW:0]       FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              dn_en_q;
    logic              en_rise, en_fall;

    logic              pend_valid;
    logic [WA-1:0]     pend_waddr;
    logic [7:0]        pend_lo;

    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic              fifo_full;
    logic [EW-1:0]     head;

    logic              byte_ok, byte_acc, addr_bad, pair_hit;
    logic              push_req, push_ok, push_drop, pop;
    logic [EW-1:0]     push_entry;

    logic [ADDR_W-1:0] count_q;
    logic              mem_req_q;

    assign en_rise   = dn_en & ~dn_en_q;
    assign en_fall   = ~dn_en & dn_en_q;
    assign byte_ok   = (state_q == S_LOAD) & dn_en & dn_wr;
    assign pair_hit  = pend_valid & (pend_waddr == dn_addr[ADDR_W-1:1]);
    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign pop       = mem_req_q & mem_ack;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign push_drop = push_req & ~push_ok;
    assign head      = fifo_mem[rd_ptr];

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_req_q ? {head[EW-1:16], 1'b0} : '0;
    assign mem_din   = mem_req_q ? head[15:0] : 16'h0000;
    assign busy      = (state_q == S_LOAD) | (state_q == S_DRAIN);

    // Byte packing: decide whether this cycle pushes a word and whether the byte counts
    always_comb begin
        push_req   = 1'b0;
        push_entry = '0;
        byte_acc   = 1'b0;
        addr_bad   = 1'b0;
        if (byte_ok) begin
            if (!dn_addr[0]) begin
                byte_acc = 1'b1;
                if (pend_valid) begin
                    push_req   = 1'b1;
                    push_entry = {pend_waddr, 8'h00, pend_lo};
                end
            end else if (pair_hit) begin
                byte_acc   = 1'b1;
                push_req   = 1'b1;
                push_entry = {pend_waddr, dn_data, pend_lo};
            end else begin
                addr_bad = 1'b1;
            end
        end else if (en_fall && pend_valid) begin
            push_req   = 1'b1;
            push_entry = {pend_waddr, 8'h00, pend_lo};
        end
    end

    // Next-state logic; a new download restarts LOAD from any state
    always_comb begin
        state_d = state_q;
        if (en_rise) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD:  if (en_fall) state_d = S_DRAIN;
                S_DRAIN: if (fifo_cnt == '0 && !mem_req_q) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // State register and dn_en edge history
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= S_IDLE;
            dn_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dn_en_q <= dn_en;
        end
    end

    // Pending even byte (low half of the next word)
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            pend_valid <= 1'b0;
            pend_waddr <= '0;
            pend_lo    <= 8'h00;
        end else if (en_rise) begin
            pend_valid <= 1'b0;
        end else if (byte_ok && !dn_addr[0]) begin
            pend_valid <= 1'b1;
            pend_waddr <= dn_addr[ADDR_W-1:1];
            pend_lo    <= dn_data;
        end else if ((byte_ok && pair_hit) || en_fall) begin
            pend_valid <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk_25) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Write request: drops on ack, re-arms one idle cycle later if words remain
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            mem_req_q <= 1'b0;
        end else if (pop) begin
            mem_req_q <= 1'b0;
        end else if (!mem_req_q && fifo_cnt != '0) begin
            mem_req_q <= 1'b1;
        end
    end

    // Byte count, sticky errors and the picture-valid verdict taken on DRAIN->DONE
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            count_q      <= '0;
            err_overflow <= 1'b0;
            err_addr     <= 1'b0;
            pic_valid    <= 1'b0;
        end else if (en_rise) begin
            count_q      <= '0;
            err_overflow <= 1'b0;
            err_addr     <= 1'b0;
            pic_valid    <= 1'b0;
        end else begin
            if (byte_acc && count_q != '1) count_q <= count_q + 1'b1;
            if (push_drop) err_overflow <= 1'b1;
            if (addr_bad)  err_addr     <= 1'b1;
            if (state_q == S_DRAIN && state_d == S_DONE)
                pic_valid <= (count_q >= FRAME_CNT) & ~err_overflow & ~err_addr;
        end
    end

`ifdef BGW_CHECKSUM_EN
    logic [15:0] cks_q;

    // Wrap-around sum of accepted bytes; byte_acc is only ever set in LOAD
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            cks_q <= 16'h0000;
        end else if (en_rise) begin
            cks_q <= 16'h0000;
        end else if (byte_acc) begin
            cks_q <= cks_q + {8'h00, dn_data};
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
